// File: rtl/plab5_mcore_mem_domain_filter.sv
// plab5_mcore_mem_domain_filter
// Single-outstanding memory firewall between the arbiter and memory.
// Domain-0 requests at or above p_boundary are bounced locally with a
// zero-data response; everything else is forwarded unchanged.
// Optional: define PLAB5_MEM_FILTER_VIOLATION_CNT_EN to add the saturating
// violation_cnt output.
module plab5_mcore_mem_domain_filter #(
  parameter int          p_opaque_nbits = 8,
  parameter int          p_addr_nbits   = 32,
  parameter int          p_data_nbits   = 32,
  parameter logic [31:0] p_boundary     = 32'h0000_8000,
  localparam int         c_rqc          = 3 + p_opaque_nbits + p_addr_nbits + 2,
  localparam int         c_rsc          = 3 + p_opaque_nbits + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  // upstream request
  input  logic                    in_req_val,
  output logic                    in_req_rdy,
  input  logic [c_rqc-1:0]        in_req_control,
  input  logic [p_data_nbits-1:0] in_req_data,
  input  logic                    in_req_domain,
  // upstream response
  output logic                    in_resp_val,
  input  logic                    in_resp_rdy,
  output logic [c_rsc-1:0]        in_resp_control,
  output logic [p_data_nbits-1:0] in_resp_data,
  output logic                    in_resp_domain,
  // memory request
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [c_rqc-1:0]        mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,
  output logic                    mem_req_domain,
  // memory response
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [c_rsc-1:0]        mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  input  logic                    mem_resp_domain
`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
  ,
  output logic [15:0]             violation_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [p_addr_nbits-1:0] c_bound = p_addr_nbits'(p_boundary);

  logic [1:0]              state_q, state_d;
  logic [c_rqc-1:0]        req_ctrl_q, req_ctrl_d;
  logic [p_data_nbits-1:0] req_data_q, req_data_d;
  logic                    req_dom_q, req_dom_d;
  logic [c_rsc-1:0]        resp_ctrl_q, resp_ctrl_d;
  logic [p_data_nbits-1:0] resp_data_q, resp_data_d;
  logic                    resp_dom_q, resp_dom_d;

  logic [p_addr_nbits-1:0] req_addr;
  logic                    deny;
  logic                    accept;

  // Address field sits just above the 2-bit len; domain 1 is never denied.
  assign req_addr = in_req_control[p_addr_nbits+1:2];
  assign deny     = !in_req_domain && (req_addr >= c_bound);
  assign accept   = (state_q == IDLE) && in_req_val;

  // Next-state and field capture for the single in-flight transaction.
  always_comb begin
    state_d     = state_q;
    req_ctrl_d  = req_ctrl_q;
    req_data_d  = req_data_q;
    req_dom_d   = req_dom_q;
    resp_ctrl_d = resp_ctrl_q;
    resp_data_d = resp_data_q;
    resp_dom_d  = resp_dom_q;
    case (state_q)
      IDLE: if (in_req_val) begin
        req_ctrl_d = in_req_control;
        req_data_d = in_req_data;
        req_dom_d  = in_req_domain;
        if (deny) begin
          // Bounce locally: echo {type, opaque, len}, return zero data.
          resp_ctrl_d = {in_req_control[c_rqc-1 -: 3+p_opaque_nbits], in_req_control[1:0]};
          resp_data_d = '0;
          resp_dom_d  = in_req_domain;
          state_d     = RESP;
        end else begin
          state_d = FWD;
        end
      end
      FWD:  if (mem_req_rdy) state_d = WAIT;
      WAIT: if (mem_resp_val) begin
        resp_ctrl_d = mem_resp_control;
        resp_data_d = mem_resp_data;
        resp_dom_d  = mem_resp_domain;
        state_d     = RESP;
      end
      RESP: if (in_resp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured fields; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ctrl_q  <= '0;
      req_data_q  <= '0;
      req_dom_q   <= 1'b0;
      resp_ctrl_q <= '0;
      resp_data_q <= '0;
      resp_dom_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ctrl_q  <= req_ctrl_d;
      req_data_q  <= req_data_d;
      req_dom_q   <= req_dom_d;
      resp_ctrl_q <= resp_ctrl_d;
      resp_data_q <= resp_data_d;
      resp_dom_q  <= resp_dom_d;
    end
  end

  // Handshake signals are pure state decodes, so each is live in one state only.
  assign in_req_rdy      = (state_q == IDLE);
  assign mem_req_val     = (state_q == FWD);
  assign mem_resp_rdy    = (state_q == WAIT);
  assign in_resp_val     = (state_q == RESP);

  assign mem_req_control = req_ctrl_q;
  assign mem_req_data    = req_data_q;
  assign mem_req_domain  = req_dom_q;
  assign in_resp_control = resp_ctrl_q;
  assign in_resp_data    = resp_data_q;
  assign in_resp_domain  = resp_dom_q;

`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
  logic [15:0] violation_cnt_q;

  // Count denied accepts, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      violation_cnt_q <= '0;
    else if (accept && deny && (violation_cnt_q != 16'hFFFF))
      violation_cnt_q <= violation_cnt_q + 16'd1;
  end

  assign violation_cnt = violation_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_domain_filter.sv
// Bench for plab5_mcore_mem_domain_filter: directed transactions, a
// transaction-level expectation queue checked every cycle, and a small
// memory responder with programmable stall.
module tb_plab5_mcore_mem_domain_filter;
  localparam int RQC = 45;
  localparam int RSC = 13;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_req_val = 1'b0;
  logic           in_req_rdy;
  logic [RQC-1:0] in_req_control = '0;
  logic [31:0]    in_req_data = '0;
  logic           in_req_domain = 1'b0;
  logic           in_resp_val;
  logic           in_resp_rdy = 1'b0;
  logic [RSC-1:0] in_resp_control;
  logic [31:0]    in_resp_data;
  logic           in_resp_domain;
  logic           mem_req_val;
  logic           mem_req_rdy = 1'b0;
  logic [RQC-1:0] mem_req_control;
  logic [31:0]    mem_req_data;
  logic           mem_req_domain;
  logic           mem_resp_val = 1'b0;
  logic           mem_resp_rdy;
  logic [RSC-1:0] mem_resp_control = '0;
  logic [31:0]    mem_resp_data = '0;
  logic           mem_resp_domain = 1'b0;
`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
  logic [15:0]    violation_cnt;
`endif

  plab5_mcore_mem_domain_filter dut (
    .clk(clk), .reset(reset),
    .in_req_val(in_req_val), .in_req_rdy(in_req_rdy), .in_req_control(in_req_control),
    .in_req_data(in_req_data), .in_req_domain(in_req_domain),
    .in_resp_val(in_resp_val), .in_resp_rdy(in_resp_rdy), .in_resp_control(in_resp_control),
    .in_resp_data(in_resp_data), .in_resp_domain(in_resp_domain),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_control(mem_req_control),
    .mem_req_data(mem_req_data), .mem_req_domain(mem_req_domain),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_control(mem_resp_control),
    .mem_resp_data(mem_resp_data), .mem_resp_domain(mem_resp_domain)
`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
    , .violation_cnt(violation_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int mreq_cnt = 0;

  // Expected memory requests {control, data, domain} and responses likewise.
  logic [RQC+32:0] exp_mem_q[$];
  logic [RSC+32:0] exp_resp_q[$];
  logic [RSC+32:0] last_resp = '0;

  int          stall_left = 0;
  bit          mem_hold = 1'b0;
  bit          pend = 1'b0;
  bit          fire_pending = 1'b0;
  logic [31:0] mem_rdata = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Cycle-by-cycle checker against the expectation queues.
  always @(negedge clk) begin
    if (!reset) begin
      chk("one_handshake_live",
          128'($countones({in_req_rdy, mem_req_val, mem_resp_rdy, in_resp_val})), 128'(1));
      if (mem_req_val) begin
        if (exp_mem_q.size() == 0) chk("mem_req_unexpected", 128'(1), 128'(0));
        else begin
          chk("mem_req_fields", 128'({mem_req_control, mem_req_data, mem_req_domain}),
              128'(exp_mem_q[0]));
          if (mem_req_rdy) begin
            void'(exp_mem_q.pop_front());
            mreq_cnt++;
          end
        end
      end
      if (in_resp_val) begin
        last_resp = {in_resp_control, in_resp_data, in_resp_domain};
        if (exp_resp_q.size() == 0) chk("in_resp_unexpected", 128'(1), 128'(0));
        else begin
          chk("in_resp_fields", 128'(last_resp), 128'(exp_resp_q[0]));
          if (in_resp_rdy) void'(exp_resp_q.pop_front());
        end
      end
    end
  end

  // Memory model: stalls mem_req_rdy stall_left cycles, then answers on the
  // following cycle with control echoed from the request and data mem_rdata.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      pend = 1'b0; fire_pending = 1'b0;
      mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
    end else begin
      if (fire_pending) pend = 1'b0;
      if (mem_req_val) begin
        if (stall_left > 0) begin
          mem_req_rdy = 1'b0;
          stall_left--;
        end else begin
          mem_req_rdy      = 1'b1;
          pend             = 1'b1;
          mem_resp_control = {mem_req_control[RQC-1 -: 11], mem_req_control[1:0]};
          mem_resp_domain  = mem_req_domain;
          mem_resp_data    = mem_rdata;
        end
      end else begin
        mem_req_rdy = 1'b0;
      end
      mem_resp_val = pend && !mem_hold;
      fire_pending = mem_resp_val && mem_resp_rdy;
    end
  end

  task automatic txn(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic dom, input logic [31:0] rdata,
                     input int mstall, input int rstall, input int exp_lat, input int exp_mreq,
                     input string nm);
    logic [RQC-1:0] ctrl;
    bit             deny;
    int             acc, n, m0;
    ctrl = {typ, opq, addr, 2'b00};
    deny = (dom == 1'b0) && (addr >= 32'h0000_8000);
    if (!deny) exp_mem_q.push_back({ctrl, wdata, dom});
    exp_resp_q.push_back({typ, opq, 2'b00, (deny ? 32'h0 : rdata), dom});
    mem_rdata = rdata; stall_left = mstall; m0 = mreq_cnt;
    @(posedge clk); #1;
    in_req_val = 1'b1; in_req_control = ctrl; in_req_data = wdata; in_req_domain = dom;
    n = 0;
    @(negedge clk);
    while (!in_req_rdy && n < 50) begin @(negedge clk); n++; end
    acc = cyc;
    @(posedge clk); #1;
    in_req_val = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_resp_val && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 128'(cyc - acc), 128'(exp_lat));
    repeat (rstall) @(negedge clk);
    @(posedge clk); #1;
    in_resp_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_resp_rdy = 1'b0;
    chk({nm, "_mem_reqs"}, 128'(mreq_cnt - m0), 128'(exp_mreq));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_req_rdy", 128'(in_req_rdy), 128'(1));
    chk("rst_mem_req_val", 128'(mem_req_val), 128'(0));
    chk("rst_in_resp_val", 128'(in_resp_val), 128'(0));
    chk("rst_mem_req_ctrl", 128'(mem_req_control), 128'(0));
    chk("rst_in_resp_data", 128'(in_resp_data), 128'(0));
`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
    chk("rst_violation_cnt", 128'(violation_cnt), 128'(0));
`endif

    // Allowed read, immediate memory: 3-cycle latency, data/opaque passed.
    txn(3'd0, 8'h05, 32'h0000_0100, 32'h0, 1'b0, 32'hCAFE_F00D, 0, 0, 3, 1, "allowed_rd");
    chk("allowed_rd_data", 128'(last_resp[32:1]), 128'(32'hCAFE_F00D));
    chk("allowed_rd_opaque", 128'(last_resp[42:35]), 128'(8'h05));

    // Denied write at the boundary: local response, zero data, type write.
    txn(3'd1, 8'h11, 32'h0000_8000, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF, 0, 0, 1, 0, "denied_wr");
    chk("denied_wr_data", 128'(last_resp[32:1]), 128'(0));
    chk("denied_wr_type", 128'(last_resp[45:43]), 128'(3'd1));
    chk("denied_wr_domain", 128'(last_resp[0]), 128'(0));
`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
    chk("denied_wr_cnt", 128'(violation_cnt), 128'(1));
`endif

    // Boundary cases.
    txn(3'd0, 8'h21, 32'h0000_7FFC, 32'h0, 1'b0, 32'h1111_2222, 0, 0, 3, 1, "bnd_d0_below");
    txn(3'd1, 8'h22, 32'hFFFF_0000, 32'hA5A5_5A5A, 1'b1, 32'h0, 0, 0, 3, 1, "bnd_d1_high");
    chk("bnd_d1_domain", 128'(last_resp[0]), 128'(1));
    txn(3'd0, 8'h23, 32'h0000_8000, 32'h0, 1'b0, 32'h3333_4444, 0, 0, 1, 0, "bnd_d0_at");
    txn(3'd0, 8'h24, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h5555_6666, 0, 0, 1, 0, "bnd_d0_top");

    // Backpressure on both sides: 4 stalled FWD cycles, 3 held RESP cycles.
    txn(3'd1, 8'h7E, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'h7777_8888, 4, 3, 7, 1, "bp");

    // Reset while waiting on memory: no response, clean restart.
    stall_left = 0; mem_hold = 1'b1;
    exp_mem_q.push_back({3'd0, 8'h31, 32'h0000_0200, 2'b00, 32'h0, 1'b0});
    @(posedge clk); #1;
    in_req_val = 1'b1; in_req_control = {3'd0, 8'h31, 32'h0000_0200, 2'b00};
    in_req_data = 32'h0; in_req_domain = 1'b0;
    @(posedge clk); #1;
    in_req_val = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_resp_rdy && n < 50) begin @(negedge clk); n++; end
    chk("rst_wait_reached", 128'(mem_resp_rdy), 128'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_resp_val", 128'(in_resp_val), 128'(0));
    chk("rst_mid_mem_req_val", 128'(mem_req_val), 128'(0));
    chk("rst_mid_in_req_rdy", 128'(in_req_rdy), 128'(1));
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_resp", 128'(in_resp_val), 128'(0));
    end
    txn(3'd0, 8'h32, 32'h0000_0300, 32'h0, 1'b0, 32'h9999_AAAA, 0, 0, 3, 1, "post_rst");
    chk("post_rst_data", 128'(last_resp[32:1]), 128'(32'h9999_AAAA));

`ifdef PLAB5_MEM_FILTER_VIOLATION_CNT_EN
    // Saturation: preload near the top, three more denials pin at 0xFFFF.
    @(posedge clk); #1;
    dut.violation_cnt_q = 16'hFFFE;
    for (int i = 0; i < 3; i++)
      txn(3'd0, 8'h40, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 0, 0, 1, 0, "sat");
    chk("sat_cnt", 128'(violation_cnt), 128'(16'hFFFF));
`endif

    repeat (2) @(negedge clk);
    chk("exp_mem_drained", 128'(exp_mem_q.size()), 128'(0));
    chk("exp_resp_drained", 128'(exp_resp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/plab5_mcore_mem_domain_filter.md
PLAB5_MCORE_MEM_DOMAIN_FILTER -- requirements
Module: plab5_mcore_mem_domain_filter

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8, message opaque width (o).
REQ-002 SHALL have parameter p_addr_nbits, default 32, address width (a).
REQ-003 SHALL have parameter p_data_nbits, default 32, data width (d).
REQ-004 SHALL have parameter p_boundary, default 32'h0000_8000, lowest domain-1-only address.
REQ-005 SHALL use widths rqc = 3+o+a+2 (req control = {type[3], opaque, addr, len[2]}, type at MSBs) and rsc = 3+o+2 (resp control = {type, opaque, len}).
REQ-006 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
REQ-007 SHALL have the following upstream request ports (from the arbiter):
- in_req_val  in  1
- in_req_rdy  out  1
- in_req_control  in  rqc
- in_req_data  in  d
- in_req_domain  in  1
REQ-008 SHALL have the following upstream response ports (to the arbiter):
- in_resp_val  out  1
- in_resp_rdy  in  1
- in_resp_control  out  rsc
- in_resp_data  out  d
- in_resp_domain  out  1
REQ-009 SHALL have the following memory request ports:
- mem_req_val  out  1
- mem_req_rdy  in  1
- mem_req_control  out  rqc
- mem_req_data  out  d
- mem_req_domain  out  1
REQ-010 SHALL have the following memory response ports:
- mem_resp_val  in  1
- mem_resp_rdy  out  1
- mem_resp_control  in  rsc
- mem_resp_data  in  d
- mem_resp_domain  in  1
REQ-011 SHALL have violation_cnt  out  16  saturating denied-request count, present only under REQ-026.

Function
REQ-012 SHALL implement FSM states IDLE, FWD, WAIT and RESP, with one transaction outstanding at most.
REQ-013 SHALL behave as follows in IDLE:
- in_req_rdy=1.
- On in_req_val&&in_req_rdy: register control, data and domain, and evaluate the permission check.
REQ-014 SHALL apply this permission check: deny iff domain==0 && addr >= p_boundary (unsigned compare); domain 1 is always allowed; reads and writes are treated identically.
REQ-015 SHALL route accepted requests as follows:
- Allowed request: IDLE->FWD.
- Denied request: IDLE->RESP, loading the local response {type, opaque, len} copied from the request, data=0, domain=request domain.
REQ-016 SHALL behave as follows in FWD:
- mem_req_val=1, driving the registered request unchanged.
- Stay in FWD until mem_req_rdy.
- On mem_req_rdy, go to WAIT.
REQ-017 SHALL behave as follows in WAIT:
- mem_resp_rdy=1.
- On mem_resp_val, capture control, data and domain, then go to RESP.
REQ-018 SHALL behave as follows in RESP:
- in_resp_val=1 with the captured response.
- Hold until in_resp_rdy, then go to IDLE.
REQ-019 SHALL keep the minimum allowed-request latency, accept to in_resp_val, at 3 cycles when mem_req_rdy and mem_resp_val are 1 immediately.
REQ-020 SHALL keep the denied-request latency, accept to in_resp_val, at exactly 1 cycle, with no mem_req_val pulse.
REQ-021 SHALL hold all val outputs at 0 and all rdy outputs at 0 outside their own state.
REQ-022 SHALL hold data/control outputs stable while their val=1 and rdy=0.
REQ-023 SHALL ignore mem_resp_val outside WAIT, with mem_resp_rdy=0 there.

Reset
REQ-024 SHALL on reset go to IDLE and clear all registered fields and violation_cnt to 0.
REQ-025 SHALL abandon any in-flight transaction when reset is asserted mid-transaction, with no response emitted; every val output SHALL read 0 in the cycle after reset.

Configuration
REQ-026 SHALL gate violation counting with macro PLAB5_MEM_FILTER_VIOLATION_CNT_EN:
- Macro defined: violation_cnt increments by 1 on each denied accept and saturates at 16'hFFFF.
- Macro undefined: the port and the counter are absent, and the filtering behaviour is unchanged.

Verification
REQ-027 SHALL cover an allowed read: domain 0, addr 0x100, opaque 0x05, memory returning data 0xCAFEF00D -> in_resp_data=0xCAFEF00D, opaque 0x05, 3-cycle latency.
REQ-028 SHALL cover a denied write: domain 0, addr 0x8000, data 0x1234 -> mem_req_val never 1; in_resp data=0, type=write, domain=0 one cycle after accept; violation_cnt=1.
REQ-029 SHALL cover the boundary: domain 0 at addr 0x7FFC -> forwarded; domain 1 at addr 0xFFFF_0000 -> forwarded; domain 0 at addr 0x8000 -> denied.
REQ-030 SHALL cover backpressure: mem_req_rdy=0 for 4 cycles then 1, and in_resp_rdy=0 for 3 cycles -> val/control held stable throughout; exactly one memory request; in_req_rdy=0 until IDLE.
REQ-031 SHALL cover reset in WAIT: assert reset one cycle -> in_resp_val=0; a new request afterwards completes normally.
REQ-032 SHALL cover saturation (macro on): preload violation_cnt to 16'hFFFE, then issue 3 denied requests -> violation_cnt=16'hFFFF.
